cache_line_ctrl: RTL

//  Parametrised miss/fill controller for the L1 instruction cache. Sweeps the tag store on

---
 rtl/cache_line_ctrl_if.sv | 41 ++++
 rtl/cache_line_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cache_line_ctrl_if.sv
// Bus bundle between the L1 instruction-cache miss/fill controller and its neighbours
// (CPU fetch port, tag/data arrays, line buffer, main memory).
interface cache_line_ctrl_if #(
    parameter int WORDS_PER_LINE = 4,
    parameter int NUM_SETS       = 16,
    parameter int CNT_W          = 32
);
    localparam int SET_W = $clog2(NUM_SETS);
    localparam int WPL_W = $clog2(WORDS_PER_LINE);

    // Handshake: re_imem is a request held by the CPU until memValid1 answers it;
    // mem_valid_mm is valid-only (no backpressure) and only counts while re_mm is high.
    logic               re_imem;
    logic               hit_imem;
    logic               flush;
    logic               mem_valid_mm;
    logic               clr;
    logic [SET_W-1:0]   clr_idx;
    logic               memValid1;
    logic               re_mm;
    logic               reset_mm;
    logic               we_cl;
    logic               we_imem;
    logic [WPL_W-1:0]   word_idx;
    logic               busy;
    logic [CNT_W-1:0]   hit_cnt;
    logic [CNT_W-1:0]   miss_cnt;
    logic [1:0]         dbg_state;

    modport slave (
        input  re_imem, hit_imem, flush, mem_valid_mm,
        output clr, clr_idx, memValid1, re_mm, reset_mm, we_cl, we_imem,
               word_idx, busy, hit_cnt, miss_cnt, dbg_state
    );

    modport master (
        output re_imem, hit_imem, flush, mem_valid_mm,
        input  clr, clr_idx, memValid1, re_mm, reset_mm, we_cl, we_imem,
               word_idx, busy, hit_cnt, miss_cnt, dbg_state
    );
endinterface

// File: rtl/cache_line_ctrl.sv
// L1 instruction-cache miss/fill controller: tag sweep, hit service, line fetch and fill.
// Optional hit/miss statistics counters enabled by defining CACHE_LINE_CTRL_STATS_EN.
module cache_line_ctrl #(
    parameter int WORDS_PER_LINE = 4,
    parameter int NUM_SETS       = 16,
    parameter int CNT_W          = 32
) (
    input  logic               clk,
    input  logic               reset,
    cache_line_ctrl_if.slave   bus
);
    localparam int SET_W = $clog2(NUM_SETS);
    localparam int WPL_W = $clog2(WORDS_PER_LINE);
    localparam logic [SET_W-1:0] LAST_SET  = SET_W'(NUM_SETS - 1);
    localparam logic [WPL_W-1:0] LAST_WORD = WPL_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_FETCH  = 2'd2,
        ST_FILL   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [SET_W-1:0] r_clr_idx;
    logic [SET_W-1:0] w_clr_idx_nxt;
    logic [WPL_W-1:0] r_word_idx;
    logic [WPL_W-1:0] w_word_idx_nxt;
    logic             r_flush_pend;
    logic             w_flush_pend_nxt;

    logic w_clr;
    logic w_mem_valid1;
    logic w_re_mm;
    logic w_reset_mm;
    logic w_we_cl;
    logic w_we_imem;
    logic w_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_INIT;
            r_clr_idx    <= '0;
            r_word_idx   <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_clr_idx    <= w_clr_idx_nxt;
            r_word_idx   <= w_word_idx_nxt;
            r_flush_pend <= w_flush_pend_nxt;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_clr_idx_nxt    = r_clr_idx;
        w_word_idx_nxt   = r_word_idx;
        w_flush_pend_nxt = r_flush_pend;
        w_clr            = 1'b0;
        w_mem_valid1     = 1'b0;
        w_re_mm          = 1'b0;
        w_reset_mm       = 1'b0;
        w_we_cl          = 1'b0;
        w_we_imem        = 1'b0;
        w_busy           = 1'b1;

        case (r_state)
            ST_INIT: begin
                // Flush requests arriving mid-sweep are absorbed by the sweep already running.
                w_clr            = 1'b1;
                w_flush_pend_nxt = 1'b0;
                w_clr_idx_nxt    = r_clr_idx + 1'b1;
                if (r_clr_idx == LAST_SET) begin
                    w_next_state = ST_LOOKUP;
                end
            end

            ST_LOOKUP: begin
                w_busy = 1'b0;
                if (bus.flush || r_flush_pend) begin
                    w_next_state     = ST_INIT;
                    w_clr_idx_nxt    = '0;
                    w_flush_pend_nxt = 1'b0;
                end else if (bus.re_imem && bus.hit_imem) begin
                    w_mem_valid1 = 1'b1;
                end else if (bus.re_imem) begin
                    w_reset_mm     = 1'b1;
                    w_word_idx_nxt = '0;
                    w_next_state   = ST_FETCH;
                end
            end

            ST_FETCH: begin
                w_re_mm = 1'b1;
                w_we_cl = bus.mem_valid_mm;
                if (bus.flush) begin
                    w_flush_pend_nxt = 1'b1;
                end
                if (bus.mem_valid_mm) begin
                    if (r_word_idx == LAST_WORD) begin
                        w_reset_mm     = 1'b1;
                        w_word_idx_nxt = '0;
                        w_next_state   = ST_FILL;
                    end else begin
                        w_word_idx_nxt = r_word_idx + 1'b1;
                    end
                end
            end

            ST_FILL: begin
                w_we_imem = 1'b1;
                if (bus.flush) begin
                    w_flush_pend_nxt = 1'b1;
                end
                if (r_word_idx == LAST_WORD) begin
                    w_reset_mm     = 1'b1;
                    w_word_idx_nxt = '0;
                    w_next_state   = ST_LOOKUP;
                end else begin
                    w_word_idx_nxt = r_word_idx + 1'b1;
                end
            end

            default: begin
                w_next_state     = ST_INIT;
                w_clr_idx_nxt    = '0;
                w_word_idx_nxt   = '0;
                w_flush_pend_nxt = 1'b0;
            end
        endcase
    end

    assign bus.clr       = w_clr;
    assign bus.clr_idx   = r_clr_idx;
    assign bus.memValid1 = w_mem_valid1;
    assign bus.re_mm     = w_re_mm;
    assign bus.reset_mm  = w_reset_mm;
    assign bus.we_cl     = w_we_cl;
    assign bus.we_imem   = w_we_imem;
    assign bus.word_idx  = r_word_idx;
    assign bus.busy      = w_busy;
    assign bus.dbg_state = r_state;

`ifdef CACHE_LINE_CTRL_STATS_EN
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_miss_cnt;
    logic             w_miss_evt;
    logic             w_init_entry;

    assign w_miss_evt   = (r_state == ST_LOOKUP) && (w_next_state == ST_FETCH);
    assign w_init_entry = (r_state != ST_INIT) && (w_next_state == ST_INIT);

    // Saturating counters; a new sweep starts a fresh statistics window.
    always_ff @(posedge clk) begin
        if (reset || w_init_entry) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_mem_valid1 && (r_hit_cnt != {CNT_W{1'b1}})) begin
                r_hit_cnt <= r_hit_cnt + 1'b1;
            end
            if (w_miss_evt && (r_miss_cnt != {CNT_W{1'b1}})) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

    assign bus.hit_cnt  = r_hit_cnt;
    assign bus.miss_cnt = r_miss_cnt;
`else
    assign bus.hit_cnt  = '0;
    assign bus.miss_cnt = '0;
`endif
endmodule
